// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - operand sequencer and result collector for the 8-bit sequential Booth multiplier
module booth_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mcand,
    input  logic [WIDTH-1:0]     in_mplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 out_error,
    output logic                 busy,
    output logic [WIDTH-1:0]     mul_inbus,
    output logic                 mul_beginsig,
    output logic                 mul_locksig,
    input  logic [WIDTH-1:0]     mul_outbus,
    input  logic                 mul_endsig
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_M,
        S_LOAD_Q,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] hist1;
    logic [WIDTH-1:0] hist0;
    logic [CW-1:0]    wdog;
    logic             wdog_expired;

    assign wdog_expired = (wdog == CW'(TIMEOUT - 1));

    // State register; reset forces IDLE so the lock drops the moment rst_n falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and strobe decode; outputs depend on state only (plus rst_n for in_ready)
    always_comb begin
        state_nx     = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        mul_inbus    = '0;
        mul_beginsig = 1'b1;
        mul_locksig  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = rst_n;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nx = S_LOAD_M;
                end
            end
            S_LOAD_M: begin
                mul_beginsig = 1'b0;
                mul_locksig  = 1'b1;
                mul_inbus    = mcand_q;
                state_nx     = S_LOAD_Q;
            end
            S_LOAD_Q: begin
                mul_locksig = 1'b1;
                mul_inbus   = mplier_q;
                state_nx    = S_WAIT;
            end
            S_WAIT: begin
                mul_locksig = 1'b1;
                mul_inbus   = mplier_q;
                if (mul_endsig || wdog_expired) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Operand latch, output history, watchdog and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            hist1       <= '0;
            hist0       <= '0;
            wdog        <= '0;
            out_product <= '0;
            out_error   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand_q  <= in_mcand;
                        mplier_q <= in_mplier;
                    end
                end
                S_LOAD_Q: begin
                    wdog  <= '0;
                    hist1 <= '0;
                    hist0 <= '0;
                end
                S_WAIT: begin
                    hist1 <= hist0;
                    hist0 <= mul_outbus;
                    wdog  <= wdog + CW'(1);
                    // The product bytes precede endsig on the bus, so they are
                    // already in the history when endsig is seen.
                    if (mul_endsig) begin
                        out_product <= {hist1, hist0};
                        out_error   <= 1'b0;
                    end else if (wdog_expired) begin
                        out_product <= '0;
                        out_error   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - self-checking bench for booth_seq_ctrl
module tb_booth_seq_ctrl;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_mcand = '0;
    logic [7:0]  in_mplier = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_product;
    logic        out_error;
    logic        busy;
    logic [7:0]  mul_inbus;
    logic        mul_beginsig;
    logic        mul_locksig;
    logic [7:0]  mul_outbus = '0;
    logic        mul_endsig = 1'b0;

    int passed = 0;
    int total  = 0;

    booth_seq_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mcand(in_mcand), .in_mplier(in_mplier),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_error(out_error), .busy(busy),
        .mul_inbus(mul_inbus), .mul_beginsig(mul_beginsig), .mul_locksig(mul_locksig),
        .mul_outbus(mul_outbus), .mul_endsig(mul_endsig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mc;
        logic [7:0]  mp;
        int          lat;
        bit          spur;
        int          hold;
        logic [15:0] exp_p;
        bit          exp_e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] model_product(input logic [7:0] mc, input logic [7:0] mp);
        int p;
        p = $signed(mc) * $signed(mp);
        return p[15:0];
    endfunction

    // One full operation; lat = WAIT cycle (1-based) with endsig, 0 = never
    task automatic do_op(input string nm, input vec_t v);
        logic [15:0] mp_bytes;
        int seen;
        mp_bytes = model_product(v.mc, v.mp);
        seen = 0;
        in_valid = 1'b1; in_mcand = v.mc; in_mplier = v.mp;
        chk({nm, " in_ready idle"}, in_ready, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk({nm, " loadm inbus"}, mul_inbus, v.mc);
        chk({nm, " loadm begin"}, mul_beginsig, 0);
        chk({nm, " loadm lock"}, mul_locksig, 1);
        chk({nm, " loadm busy"}, busy, 1);
        mul_endsig = v.spur;
        @(posedge clk); @(negedge clk);
        chk({nm, " loadq inbus"}, mul_inbus, v.mp);
        chk({nm, " loadq begin"}, mul_beginsig, 1);
        chk({nm, " loadq lock"}, mul_locksig, 1);
        @(posedge clk); @(negedge clk);
        mul_endsig = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            if (out_valid) begin
                seen = i;
                break;
            end
            if (v.lat > 0 && i == v.lat - 2) mul_outbus = mp_bytes[15:8];
            else if (v.lat > 0 && i == v.lat - 1) mul_outbus = mp_bytes[7:0];
            else mul_outbus = 8'($urandom);
            mul_endsig = (v.lat > 0 && i == v.lat);
            @(posedge clk); @(negedge clk);
        end
        mul_endsig = 1'b0;
        chk({nm, " done latency"}, seen, (v.lat > 0) ? v.lat + 1 : TIMEOUT + 1);
        chk({nm, " product"}, out_product, v.exp_p);
        chk({nm, " error"}, out_error, v.exp_e);
        chk({nm, " done lock"}, mul_locksig, 0);
        for (int h = 0; h < v.hold; h++) begin
            out_ready = 1'b0;
            in_valid = 1'b1; in_mcand = 8'($urandom); in_mplier = 8'($urandom);
            mul_endsig = 1'b1;
            @(posedge clk); @(negedge clk);
            chk({nm, " bp valid"}, out_valid, 1);
            chk({nm, " bp product"}, out_product, v.exp_p);
            chk({nm, " bp in_ready"}, in_ready, 0);
        end
        mul_endsig = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " idle valid"}, out_valid, 0);
        chk({nm, " idle busy"}, busy, 0);
        chk({nm, " idle in_ready"}, in_ready, 1);
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        tbl.push_back('{8'd7,   8'd6,   20, 1'b0, 0, 16'h002A, 1'b0});
        tbl.push_back('{8'hFD,  8'h05,  20, 1'b0, 0, 16'hFFF1, 1'b0});
        tbl.push_back('{8'h80,  8'h80,  20, 1'b0, 0, 16'h4000, 1'b0});
        tbl.push_back('{8'd9,   8'd9,   0,  1'b0, 0, 16'h0000, 1'b1});
        tbl.push_back('{8'd5,   8'hFF,  4,  1'b0, 0, 16'hFFFB, 1'b0});
        tbl.push_back('{8'd12,  8'd11,  7,  1'b0, 5, 16'h0084, 1'b0});
        tbl.push_back('{8'hF0,  8'h10,  10, 1'b1, 0, 16'hFF00, 1'b0});
        tbl.push_back('{8'd127, 8'h80,  3,  1'b0, 0, 16'hC080, 1'b0});

        repeat (2) @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst lock", mul_locksig, 0);
        chk("rst begin", mul_beginsig, 1);
        chk("rst valid", out_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("rel in_ready", in_ready, 1);
        chk("rel product", out_product, 0);
        chk("rel error", out_error, 0);
        chk("rel busy", busy, 0);
        chk("rel inbus", mul_inbus, 0);
        @(negedge clk);

        foreach (tbl[k]) do_op($sformatf("vec%0d", k), tbl[k]);

        // Reset at WAIT cycle 5
        in_valid = 1'b1; in_mcand = 8'd3; in_mplier = 8'd4;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
        end
        chk("mid wait lock", mul_locksig, 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst lock", mul_locksig, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mul_endsig = 1'b1;
            @(posedge clk); @(negedge clk);
            chk("post rst no valid", out_valid, 0);
        end
        mul_endsig = 1'b0;
        do_op("after rst", '{8'hFE, 8'd9, 12, 1'b0, 0, 16'hFFEE, 1'b0});

        for (int r = 0; r < 20; r++) begin
            rv.mc    = 8'($urandom);
            rv.mp    = 8'($urandom);
            rv.lat   = $urandom_range(3, 50);
            rv.spur  = 1'($urandom);
            rv.hold  = $urandom_range(0, 3);
            rv.exp_p = model_product(rv.mc, rv.mp);
            rv.exp_e = 1'b0;
            do_op($sformatf("rand%0d", r), rv);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
